// File: rtl/amf_stage_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : amf_stage_ctrl_if                                      |
// | Description : Pixel-in, sorter-statistics and result-out bundle for  |
// |               the adaptive median filter stage controller.           |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface amf_stage_ctrl_if #(
  parameter int W  = 8,
  parameter int IW = 2,
  parameter int CW = 16
) ();
  // Centre pixel input handshake
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  zxy;
  // Window statistics request/acknowledge
  logic          st_req;
  logic          st_ack;
  logic [IW-1:0] win_idx;
  logic [W-1:0]  zmin;
  logic [W-1:0]  zmed;
  logic [W-1:0]  zmax;
  // Result output handshake
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_pix;
  logic          out_sel;
  logic [CW-1:0] fb_cnt;

  // Controller side
  modport master (
    input  in_valid, zxy, st_ack, zmin, zmed, zmax, out_ready,
    output in_ready, st_req, win_idx, out_valid, out_pix, out_sel, fb_cnt
  );

  // Environment side (pixel source, sorter, result sink)
  modport slave (
    output in_valid, zxy, st_ack, zmin, zmed, zmax, out_ready,
    input  in_ready, st_req, win_idx, out_valid, out_pix, out_sel, fb_cnt
  );
endinterface
`default_nettype wire

// File: rtl/amf_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : amf_stage_ctrl                                         |
// | Description : Per-pixel sequencing controller for the adaptive       |
// |               median filter. Steps window sizes, runs Level A/B      |
// |               tests and produces the filtered pixel.                 |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module amf_stage_ctrl #(
  parameter int W    = 8,
  parameter int NWIN = 3,
  parameter int IW   = 2,
  parameter int CW   = 16
) (
  input  wire logic           clk,
  input  wire logic           rst,
  amf_stage_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_EVAL_A = 3'd2,
    S_EVAL_B = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  localparam logic [IW-1:0] c_last_idx = IW'(NWIN - 1);
  localparam logic [CW-1:0] c_fb_max   = '1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_zxy;
  logic [W-1:0]  r_zmin;
  logic [W-1:0]  r_zmed;
  logic [W-1:0]  r_zmax;
  logic [IW-1:0] r_win_idx;
  logic [W-1:0]  r_out_pix;
  logic          r_out_sel;
  logic [CW-1:0] r_fb_cnt;

  logic          w_lvl_a;
  logic          w_lvl_b;
  logic          w_last;

  // Tests use latched statistics only, so no input reaches an output combinationally.
  // Equality is a failure in both tests.
  assign w_lvl_a = (r_zmin < r_zmed) && (r_zmed < r_zmax);
  assign w_lvl_b = (r_zmin < r_zxy)  && (r_zxy  < r_zmax);
  assign w_last  = (r_win_idx == c_last_idx);

  // Handshake outputs are pure state decodes; st_req falls with the async reset.
  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.st_req    = (r_state == S_REQ);
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.win_idx   = r_win_idx;
  assign bus.out_pix   = r_out_pix;
  assign bus.out_sel   = r_out_sel;
  assign bus.fb_cnt    = r_fb_cnt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.in_valid) w_state_nxt = S_REQ;
      S_REQ:    if (bus.st_ack)   w_state_nxt = S_EVAL_A;
      S_EVAL_A: begin
        if (w_lvl_a)     w_state_nxt = S_EVAL_B;
        else if (w_last) w_state_nxt = S_OUT;
        else             w_state_nxt = S_REQ;
      end
      S_EVAL_B: w_state_nxt = S_OUT;
      S_OUT:    if (bus.out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch pixel and statistics, step the window, form the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zxy     <= '0;
      r_zmin    <= '0;
      r_zmed    <= '0;
      r_zmax    <= '0;
      r_win_idx <= '0;
      r_out_pix <= '0;
      r_out_sel <= 1'b0;
      r_fb_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_zxy     <= bus.zxy;
            r_win_idx <= '0;
          end
        end
        S_REQ: begin
          if (bus.st_ack) begin
            r_zmin <= bus.zmin;
            r_zmed <= bus.zmed;
            r_zmax <= bus.zmax;
          end
        end
        S_EVAL_A: begin
          if (!w_lvl_a) begin
            if (w_last) begin
              // Largest window still has an impulse median: substitute it anyway.
              r_out_pix <= r_zmed;
              r_out_sel <= 1'b0;
              if (r_fb_cnt != c_fb_max) r_fb_cnt <= r_fb_cnt + CW'(1);
            end else begin
              r_win_idx <= r_win_idx + IW'(1);
            end
          end
        end
        S_EVAL_B: begin
          if (w_lvl_b) begin
            r_out_pix <= r_zxy;
            r_out_sel <= 1'b1;
          end else begin
            r_out_pix <= r_zmed;
            r_out_sel <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_amf_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_amf_stage_ctrl                                      |
// | Description : Scoreboard bench for amf_stage_ctrl with a sorter      |
// |               responder and an output monitor.                       |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_amf_stage_ctrl;

  logic clk;
  logic rst;

  amf_stage_ctrl_if #(.W(8), .IW(2), .CW(2)) bus ();

  amf_stage_ctrl #(.W(8), .NWIN(3), .IW(2), .CW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] sb_q[$];       // {out_pix, out_sel}
  logic [1:0] exp_idx_q[$];  // expected win_idx per statistics handshake
  logic [7:0] t_min[3];
  logic [7:0] t_med[3];
  logic [7:0] t_max[3];
  int         ack_dly = 0;
  int         exp_fb  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input int i, input logic [7:0] mn, input logic [7:0] md, input logic [7:0] mx);
    t_min[i] = mn;
    t_med[i] = md;
    t_max[i] = mx;
  endtask

  // Sorter model: answers st_req after ack_dly cycles with the table entry for win_idx.
  initial begin
    int       wait_cnt;
    logic [1:0] hold_idx;
    wait_cnt = 0;
    hold_idx = '0;
    bus.st_ack = 1'b0;
    bus.zmin = '0;
    bus.zmed = '0;
    bus.zmax = '0;
    forever begin
      tick();
      if (bus.st_ack) begin
        bus.st_ack = 1'b0;
      end else if (bus.st_req && !rst) begin
        if (wait_cnt == 0) hold_idx = bus.win_idx;
        else               chk("win_idx_stable", bus.win_idx, hold_idx);
        chk("in_ready_busy_req", bus.in_ready, 1'b0);
        if (wait_cnt < ack_dly) begin
          wait_cnt++;
        end else begin
          if (exp_idx_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_st_req: got idx %0d expected none", bus.win_idx);
          end else begin
            chk("win_idx", bus.win_idx, exp_idx_q.pop_front());
          end
          bus.zmin   = t_min[bus.win_idx];
          bus.zmed   = t_med[bus.win_idx];
          bus.zmax   = t_max[bus.win_idx];
          bus.st_ack = 1'b1;
          wait_cnt   = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Output monitor: pops the scoreboard on each accepted result, checks hold stability.
  initial begin
    logic       prev_hold;
    logic [8:0] prev_val;
    logic [8:0] exp;
    prev_hold = 1'b0;
    prev_val  = '0;
    forever begin
      @(negedge clk);
      if (rst || !bus.out_valid) begin
        prev_hold = 1'b0;
      end else begin
        chk("in_ready_busy_out", bus.in_ready, 1'b0);
        if (prev_hold) chk("out_hold_stable", {bus.out_pix, bus.out_sel}, prev_val);
        if (bus.out_ready) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got pix %0d sel %0d expected none", bus.out_pix, bus.out_sel);
          end else begin
            exp = sb_q.pop_front();
            chk("out_pix", bus.out_pix, exp[8:1]);
            chk("out_sel", bus.out_sel, exp[0]);
          end
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          prev_val  = {bus.out_pix, bus.out_sel};
        end
      end
    end
  end

  // One complete pixel. Latency counts edges from the accept edge to out_valid.
  task automatic send_pixel(input logic [7:0] px, input int nwin, input logic [7:0] e_pix,
                            input logic e_sel, input int e_lat, input int a_dly,
                            input int r_dly, input logic fallback);
    int lat;
    sb_q.push_back({e_pix, e_sel});
    for (int i = 0; i < nwin; i++) exp_idx_q.push_back(2'(i));
    ack_dly = a_dly;
    chk("in_ready_idle", bus.in_ready, 1'b1);
    bus.zxy      = px;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("latency", lat, e_lat);
    if (!bus.out_valid) return;
    for (int d = 0; d < r_dly; d++) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("out_valid_drop", bus.out_valid, 1'b0);
    if (fallback && exp_fb < 3) exp_fb++;
    chk("fb_cnt", bus.fb_cnt, exp_fb);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.zxy       = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_win(i, 8'd0, 8'd0, 8'd0);
    tick();
    tick();
    // Reset state
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_st_req", bus.st_req, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_win_idx", bus.win_idx, 2'd0);
    chk("rst_out_pix", bus.out_pix, 8'd0);
    chk("rst_out_sel", bus.out_sel, 1'b0);
    chk("rst_fb_cnt", bus.fb_cnt, 2'd0);
    rst = 1'b0;
    tick();

    // Pass-through
    set_win(0, 8'd10, 8'd50, 8'd200);
    send_pixel(8'd100, 1, 8'd100, 1'b1, 3, 0, 0, 1'b0);
    chk("win_idx_held0", bus.win_idx, 2'd0);
    // Impulse: zxy == zmax fails Level B
    set_win(0, 8'd10, 8'd50, 8'd255);
    send_pixel(8'd255, 1, 8'd50, 1'b0, 3, 0, 0, 1'b0);
    // zxy == zmin fails Level B
    set_win(0, 8'd10, 8'd50, 8'd200);
    send_pixel(8'd10, 1, 8'd50, 1'b0, 3, 0, 0, 1'b0);
    // Escalation to 5x5, Level B fails
    set_win(0, 8'd0, 8'd0, 8'd255);
    set_win(1, 8'd5, 8'd60, 8'd250);
    send_pixel(8'd0, 2, 8'd60, 1'b0, 5, 0, 0, 1'b0);
    chk("win_idx_esc", bus.win_idx, 2'd1);
    // Escalation to 7x7, zmed == zmax fails A at 5x5, Level B passes at 7x7
    set_win(1, 8'd4, 8'd90, 8'd90);
    set_win(2, 8'd3, 8'd9, 8'd20);
    send_pixel(8'd15, 3, 8'd15, 1'b1, 7, 0, 0, 1'b0);
    // Fallback: Level A fails at every size; counter saturates at 3
    set_win(0, 8'd0, 8'd0, 8'd100);
    set_win(1, 8'd0, 8'd0, 8'd100);
    set_win(2, 8'd0, 8'd0, 8'd100);
    for (int k = 0; k < 4; k++) send_pixel(8'd77, 3, 8'd0, 1'b0, 6, 0, 0, 1'b1);
    set_win(2, 8'd1, 8'd7, 8'd7);
    send_pixel(8'd4, 3, 8'd7, 1'b0, 6, 0, 0, 1'b1);
    // Handshake stalls: ack 5 cycles late, out_ready low 3 cycles
    set_win(0, 8'd10, 8'd50, 8'd200);
    send_pixel(8'd120, 1, 8'd120, 1'b1, 8, 5, 3, 1'b0);

    // Reset while waiting in REQ
    ack_dly = 50;
    bus.zxy = 8'd33;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("req_before_rst", bus.st_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_req_st_req", bus.st_req, 1'b0);
    chk("rst_req_in_ready", bus.in_ready, 1'b1);
    chk("rst_req_fb_cnt", bus.fb_cnt, 2'd0);
    exp_fb = 0;
    tick();
    rst = 1'b0;
    ack_dly = 0;
    tick();

    // Reset while holding a result in OUT
    set_win(0, 8'd10, 8'd50, 8'd200);
    exp_idx_q.push_back(2'd0);
    bus.zxy = 8'd100;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("out_before_rst", bus.out_valid, 1'b1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_out_pix", bus.out_pix, 8'd0);
    tick();
    rst = 1'b0;
    tick();

    // Controller recovers after reset; fallback count restarts from zero
    set_win(0, 8'd0, 8'd0, 8'd100);
    set_win(1, 8'd0, 8'd0, 8'd100);
    set_win(2, 8'd0, 8'd0, 8'd100);
    send_pixel(8'd9, 3, 8'd0, 1'b0, 6, 0, 0, 1'b1);

    tick();
    tick();
    chk("sb_empty", sb_q.size(), 0);
    chk("idx_q_empty", exp_idx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
